// File: rtl/mul32_seq_ctrl_pkg.sv
// Shared constants for the sequential 32x32 shift-and-add multiplier:
// FSM state encoding and iteration counter sizing.
package mul32_seq_ctrl_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int ITER    = 32;
    localparam int COUNT_W = 5;

    // Counter value on the final RUN iteration.
    localparam logic [COUNT_W-1:0] LAST_ITER = COUNT_W'(ITER - 1);

endpackage

// File: rtl/mul32_seq_ctrl_fa32.sv
// FullAdder32: plain combinational 32-bit adder with carry-in and carry-out.
// This is the single adder that the multiplier time-shares over its iterations.
module mul32_seq_ctrl_fa32 (
    input  logic [31:0] In1,
    input  logic [31:0] In2,
    input  logic        CI,
    output logic [31:0] Out,
    output logic        CO
);

    // 33-bit sum so the carry-out falls out of the top bit.
    assign {CO, Out} = {1'b0, In1} + {1'b0, In2} + {32'b0, CI};

endmodule

// File: rtl/mul32_seq_ctrl.sv
// Sequential unsigned 32x32->64 multiplier controller.
// One adder is reused for 32 shift-and-add iterations; the 64-bit P register
// holds {partial high, remaining multiplier bits} and shifts right each cycle.
//
// Handshake: operands transfer on a clock edge where in_valid && in_ready;
// the result transfers on an edge where out_valid && out_ready. Product is
// held stable while out_valid is high and not yet taken. abort wins over
// both handshakes and returns the block to IDLE on the next edge.
module mul32_seq_ctrl
    import mul32_seq_ctrl_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ZERO_SKIP = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     OpA,
    input  logic [WIDTH-1:0]     OpB,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 busy
);

    logic [1:0]         state;
    logic [COUNT_W-1:0] count;
    logic [WIDTH-1:0]   a_reg;
    logic [2*WIDTH-1:0] p;

    logic [WIDTH-1:0]   add_in2;
    logic [WIDTH-1:0]   add_sum;
    logic               add_co;
    logic               zero_op;

    // Add the multiplicand into the high half only when the current multiplier bit is set.
    assign add_in2 = p[0] ? a_reg : '0;
    assign zero_op = (ZERO_SKIP != 0) && ((OpA == '0) || (OpB == '0));

    mul32_seq_ctrl_fa32 u_full_adder32 (
        .In1 (p[2*WIDTH-1:WIDTH]),
        .In2 (add_in2),
        .CI  (1'b0),
        .Out (add_sum),
        .CO  (add_co)
    );

    // Controller FSM, iteration counter and P shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            count <= '0;
            a_reg <= '0;
            p     <= '0;
        end else if (abort) begin
            // P is deliberately left alone; Product is masked outside DONE.
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg <= OpA;
                        count <= '0;
                        if (zero_op) begin
                            p     <= '0;
                            state <= S_DONE;
                        end else begin
                            p     <= {{WIDTH{1'b0}}, OpB};
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // 65-bit {carry, sum, low half} shifted right by one.
                    p     <= {add_co, add_sum, p[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status and result outputs decoded from the state register.
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
        Product   = out_valid ? p : '0;
    end

endmodule
